mux1hot_rr_arb: RTL and testbench

//   Parametrised successor to the fixed 8-way one-hot mux: N-channel arbitrating mux.

---
 rtl/mux1hot_rr_arb_pkg.sv | 27 ++
 rtl/mux1hot_rr_arb_mux.sv | 26 ++
 rtl/mux1hot_rr_arb.sv | 124 ++++++++++++
 tb/tb_mux1hot_rr_arb.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mux1hot_rr_arb_pkg.sv
// ----------------------------------------------------------------------------
// Package: hbb_arb_pkg
// Purpose: Shared constants and helpers for the arbitrating one-hot mux family.
//   PRIO_RR / PRIO_FIXED select the arbitration policy of mux1hot_rr_arb.
//   onehot2idx converts a one-hot (zero-extended) vector into a channel index.
// ----------------------------------------------------------------------------
package hbb_arb_pkg;

  localparam int PRIO_RR    = 0;
  localparam int PRIO_FIXED = 1;

  // Widest one-hot vector the encoder accepts; arbiters wider than this
  // must not be built with this package.
  localparam int MAX_CH = 64;

  // OR-ing the indices of the set bits gives the exact index for a one-hot
  // input and costs only an OR tree in hardware. A zero input yields 0.
  function automatic int onehot2idx(input logic [MAX_CH-1:0] vec);
    int idx;
    idx = 0;
    for (int i = 0; i < MAX_CH; i++) begin
      if (vec[i]) idx = idx | i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/mux1hot_rr_arb_mux.sv
// ----------------------------------------------------------------------------
// Module: mux1hot_n
// Purpose: Parametric AND-OR one-hot multiplexer. With a one-hot select the
//   output is the selected channel; with an all-zero select the output is 0.
// Ports:
//   sel      in   N    one-hot (or zero) channel select
//   in_data  in   N*W  packed channel data, channel i at [i*W +: W]
//   out_data out  W    selected channel data
// ----------------------------------------------------------------------------
module mux1hot_n #(
  parameter int N = 8,
  parameter int W = 8
) (
  input  logic [N-1:0]   sel,
  input  logic [N*W-1:0] in_data,
  output logic [W-1:0]   out_data
);

  always_comb begin
    out_data = '0;
    for (int i = 0; i < N; i++) begin
      out_data = out_data | (in_data[i*W +: W] & {W{sel[i]}});
    end
  end

endmodule

// File: rtl/mux1hot_rr_arb.sv
// ----------------------------------------------------------------------------
// Module: mux1hot_rr_arb
// Purpose: N-channel arbitrating mux. A combinational arbiter (round-robin or
//   fixed priority) picks one valid channel, a one-hot mux selects its data,
//   and a registered output stage presents the beat downstream.
// Parameters:
//   N          number of input channels (>= 2, <= hbb_arb_pkg::MAX_CH)
//   W          data width per channel
//   PRIO_MODE  PRIO_RR (round-robin) or PRIO_FIXED (lowest index wins)
// Ports:
//   clk        in   1    clock, rising edge
//   rst_n      in   1    asynchronous reset, active low
//   in_valid   in   N    per-channel request
//   in_data    in   N*W  packed channel data, channel i at [i*W +: W]
//   in_ready   out  N    per-channel accept, at most one bit set
//   out_valid  out  1    output register holds a beat
//   out_data   out  W    selected beat
//   out_sel    out  N    one-hot index of the channel that produced out_data
//   out_ready  in   1    downstream accept
// ----------------------------------------------------------------------------
module mux1hot_rr_arb
  import hbb_arb_pkg::*;
#(
  parameter int N         = 8,
  parameter int W         = 8,
  parameter int PRIO_MODE = PRIO_RR
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   in_valid,
  input  logic [N*W-1:0] in_data,
  output logic [N-1:0]   in_ready,
  output logic           out_valid,
  output logic [W-1:0]   out_data,
  output logic [N-1:0]   out_sel,
  input  logic           out_ready
);

  localparam int PW = $clog2(N);

  logic [PW-1:0]     ptr;
  logic [PW-1:0]     ptr_next;
  logic [N-1:0]      grant;
  logic [MAX_CH-1:0] grant_ext;
  logic [W-1:0]      mux_out;
  logic              load;
  logic              any_valid;
  int                winner;

  // The output register can take a new beat when it is empty or being
  // drained this cycle, which gives full throughput with out_ready high.
  assign load      = !out_valid || out_ready;
  assign any_valid = |in_valid;

  // Arbiter: scan N candidates starting at ptr (round-robin) or at 0 (fixed)
  // and grant the first valid one. The candidate index wraps at N, not at
  // 2**PW, so non-power-of-two channel counts stay in range.
  always_comb begin
    logic found;
    int   cand;
    grant = '0;
    found = 1'b0;
    cand  = 0;
    for (int k = 0; k < N; k++) begin
      if (PRIO_MODE == PRIO_FIXED) begin
        cand = k;
      end else begin
        cand = int'(ptr) + k;
        if (cand >= N) cand = cand - N;
      end
      if (!found && in_valid[cand]) begin
        grant[cand] = 1'b1;
        found       = 1'b1;
      end
    end
  end

  // Nothing is accepted while reset is asserted, even though the empty
  // output register would otherwise allow a load.
  assign in_ready = (load && rst_n) ? grant : '0;

  always_comb begin
    grant_ext        = '0;
    grant_ext[N-1:0] = grant;
  end

  assign winner = onehot2idx(grant_ext);

  // Pointer moves to the channel after the winner, wrapping explicitly at N.
  always_comb begin
    if (winner >= N - 1) ptr_next = '0;
    else                 ptr_next = PW'(winner + 1);
  end

  mux1hot_n #(
    .N(N),
    .W(W)
  ) u_mux (
    .sel     (grant),
    .in_data (in_data),
    .out_data(mux_out)
  );

  // Output stage and round-robin pointer. Both hold during a stall; an
  // idle load cycle only empties the register and keeps data/sel/ptr.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
      ptr       <= '0;
    end else if (load) begin
      if (any_valid) begin
        out_valid <= 1'b1;
        out_data  <= mux_out;
        out_sel   <= grant;
        if (PRIO_MODE == PRIO_RR) ptr <= ptr_next;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mux1hot_rr_arb.sv
// ----------------------------------------------------------------------------
// Testbench: tb_mux1hot_rr_arb
// Purpose: Table-driven and randomized checks of mux1hot_rr_arb in three
//   configurations: N=8 round-robin, N=8 fixed priority, N=5 round-robin.
// ----------------------------------------------------------------------------
module tb_mux1hot_rr_arb;
  import hbb_arb_pkg::*;

  localparam int N  = 8;
  localparam int W  = 8;
  localparam int N5 = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  // Round-robin N=8 instance
  logic [N-1:0]   iv;
  logic [N*W-1:0] id;
  logic [N-1:0]   irdy;
  logic           ov;
  logic [W-1:0]   od;
  logic [N-1:0]   os;
  logic           ordy;

  // Fixed-priority N=8 instance
  logic [N-1:0]   iv_fx;
  logic [N*W-1:0] id_fx;
  logic [N-1:0]   irdy_fx;
  logic           ov_fx;
  logic [W-1:0]   od_fx;
  logic [N-1:0]   os_fx;
  logic           ordy_fx;

  // Round-robin N=5 instance
  logic [N5-1:0]   iv5;
  logic [N5*W-1:0] id5;
  logic [N5-1:0]   irdy5;
  logic            ov5;
  logic [W-1:0]    od5;
  logic [N5-1:0]   os5;
  logic            ordy5;

  mux1hot_rr_arb #(.N(N), .W(W), .PRIO_MODE(PRIO_RR)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(iv), .in_data(id), .in_ready(irdy),
    .out_valid(ov), .out_data(od), .out_sel(os), .out_ready(ordy)
  );

  mux1hot_rr_arb #(.N(N), .W(W), .PRIO_MODE(PRIO_FIXED)) dut_fx (
    .clk(clk), .rst_n(rst_n), .in_valid(iv_fx), .in_data(id_fx), .in_ready(irdy_fx),
    .out_valid(ov_fx), .out_data(od_fx), .out_sel(os_fx), .out_ready(ordy_fx)
  );

  mux1hot_rr_arb #(.N(N5), .W(W), .PRIO_MODE(PRIO_RR)) dut5 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv5), .in_data(id5), .in_ready(irdy5),
    .out_valid(ov5), .out_data(od5), .out_sel(os5), .out_ready(ordy5)
  );

  typedef struct {
    bit         rst;
    logic [7:0] iv;
    bit         ordy;
    logic [7:0] e_irdy;
    bit         e_ov;
    logic [7:0] e_sel;
    logic [7:0] e_data;
  } vec_t;

  vec_t tbl[$];
  int   checks = 0;
  int   errors = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // First valid channel scanning upward from ptr (or from 0 for fixed
  // priority), wrapping with modulo n; -1 when nothing is requesting.
  function automatic int modelPick(input logic [7:0] v, input int ptr, input bit fixed, input int n);
    for (int k = 0; k < n; k++) begin
      int c;
      c = fixed ? k : (ptr + k) % n;
      if (v[c]) return c;
    end
    return -1;
  endfunction

  // Reset with every channel requesting, then release on a falling edge.
  task automatic doReset();
    @(negedge clk);
    rst_n = 1'b0;
    iv    = '1;
    iv_fx = '1;
    iv5   = '1;
    #1;
    checkOutput("rst_out_valid", 32'(ov), 32'h0);
    checkOutput("rst_in_ready", 32'(irdy), 32'h0);
    checkOutput("rst_out_sel", 32'(os), 32'h0);
    checkOutput("rst_out_data", 32'(od), 32'h0);
    checkOutput("rst_in_ready_fx", 32'(irdy_fx), 32'h0);
    checkOutput("rst_in_ready_n5", 32'(irdy5), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic applyStimulus(input vec_t v, input int row);
    if (v.rst) doReset();
    iv   = v.iv;
    ordy = v.ordy;
    #1;
    checkOutput($sformatf("tbl%0d_in_ready", row), 32'(irdy), 32'(v.e_irdy));
    checkOutput($sformatf("tbl%0d_out_valid", row), 32'(ov), 32'(v.e_ov));
    checkOutput($sformatf("tbl%0d_out_sel", row), 32'(os), 32'(v.e_sel));
    checkOutput($sformatf("tbl%0d_out_data", row), 32'(od), 32'(v.e_data));
    @(negedge clk);
  endtask

  initial begin
    bit         pend [N];
    logic [7:0] pdata [N];
    logic [7:0] prev_v;
    logic [7:0] prev_acc;
    logic [7:0] prev_d [N];
    bit         m_valid;
    logic [7:0] m_data;
    logic [7:0] m_sel;
    int         m_ptr;
    int         g;
    int         dens;
    bit         mload;
    logic [7:0] e_irdy;

    iv = '0; ordy = 1'b1;
    iv_fx = '0; ordy_fx = 1'b1;
    iv5 = '0; ordy5 = 1'b1;
    for (int i = 0; i < N; i++) begin
      id[i*W +: W]    = 8'(16 + i);
      id_fx[i*W +: W] = 8'(16 + i);
    end
    for (int i = 0; i < N5; i++) id5[i*W +: W] = 8'(16 + i);

    // All channels valid: one beat per cycle in rotating order, then a
    // three-cycle stall, then the order resumes where it left off.
    tbl.push_back('{1'b1, 8'hFF, 1'b1, 8'h01, 1'b0, 8'h00, 8'h00});
    tbl.push_back('{1'b0, 8'hFF, 1'b1, 8'h02, 1'b1, 8'h01, 8'h10});
    tbl.push_back('{1'b0, 8'hFF, 1'b1, 8'h04, 1'b1, 8'h02, 8'h11});
    tbl.push_back('{1'b0, 8'hFF, 1'b1, 8'h08, 1'b1, 8'h04, 8'h12});
    tbl.push_back('{1'b0, 8'hFF, 1'b1, 8'h10, 1'b1, 8'h08, 8'h13});
    tbl.push_back('{1'b0, 8'hFF, 1'b1, 8'h20, 1'b1, 8'h10, 8'h14});
    tbl.push_back('{1'b0, 8'hFF, 1'b1, 8'h40, 1'b1, 8'h20, 8'h15});
    tbl.push_back('{1'b0, 8'hFF, 1'b1, 8'h80, 1'b1, 8'h40, 8'h16});
    tbl.push_back('{1'b0, 8'hFF, 1'b1, 8'h01, 1'b1, 8'h80, 8'h17});
    tbl.push_back('{1'b0, 8'hFF, 1'b0, 8'h00, 1'b1, 8'h01, 8'h10});
    tbl.push_back('{1'b0, 8'hFF, 1'b0, 8'h00, 1'b1, 8'h01, 8'h10});
    tbl.push_back('{1'b0, 8'hFF, 1'b0, 8'h00, 1'b1, 8'h01, 8'h10});
    tbl.push_back('{1'b0, 8'hFF, 1'b1, 8'h02, 1'b1, 8'h01, 8'h10});
    tbl.push_back('{1'b0, 8'hFF, 1'b1, 8'h04, 1'b1, 8'h02, 8'h11});
    // Only ch2 and ch5 valid: alternate with wrap; idle cycles keep ptr.
    tbl.push_back('{1'b1, 8'h24, 1'b1, 8'h04, 1'b0, 8'h00, 8'h00});
    tbl.push_back('{1'b0, 8'h24, 1'b1, 8'h20, 1'b1, 8'h04, 8'h12});
    tbl.push_back('{1'b0, 8'h24, 1'b1, 8'h04, 1'b1, 8'h20, 8'h15});
    tbl.push_back('{1'b0, 8'h24, 1'b1, 8'h20, 1'b1, 8'h04, 8'h12});
    tbl.push_back('{1'b0, 8'h00, 1'b1, 8'h00, 1'b1, 8'h20, 8'h15});
    tbl.push_back('{1'b0, 8'h00, 1'b1, 8'h00, 1'b0, 8'h20, 8'h15});
    tbl.push_back('{1'b0, 8'h05, 1'b1, 8'h01, 1'b0, 8'h20, 8'h15});
    tbl.push_back('{1'b0, 8'h05, 1'b1, 8'h04, 1'b1, 8'h01, 8'h10});
    tbl.push_back('{1'b0, 8'h05, 1'b0, 8'h00, 1'b1, 8'h04, 8'h12});
    tbl.push_back('{1'b0, 8'h05, 1'b1, 8'h01, 1'b1, 8'h04, 8'h12});

    for (int r = 0; r < tbl.size(); r++) applyStimulus(tbl[r], r);

    // Fixed priority: ch1 wins every cycle while ch3 starves.
    doReset();
    iv_fx = 8'h0A;
    ordy_fx = 1'b1;
    for (int c = 0; c < 6; c++) begin
      #1;
      checkOutput("fx_in_ready", 32'(irdy_fx), 32'h02);
      if (c > 0) begin
        checkOutput("fx_out_valid", 32'(ov_fx), 32'h1);
        checkOutput("fx_out_sel", 32'(os_fx), 32'h02);
        checkOutput("fx_out_data", 32'(od_fx), 32'h11);
      end
      @(negedge clk);
    end
    iv_fx = 8'h0B;
    #1;
    checkOutput("fx_in_ready_ch0", 32'(irdy_fx), 32'h01);
    @(negedge clk);

    // N=5: rotation wraps 4 -> 0, then a reset pulse mid-stream.
    doReset();
    iv5 = 5'h1F;
    ordy5 = 1'b1;
    for (int c = 0; c < 7; c++) begin
      #1;
      checkOutput("n5_in_ready", 32'(irdy5), 32'(1 << (c % 5)));
      if (c > 0) begin
        checkOutput("n5_out_sel", 32'(os5), 32'(1 << ((c - 1) % 5)));
        checkOutput("n5_out_data", 32'(od5), 32'(16 + ((c - 1) % 5)));
      end
      @(negedge clk);
    end
    rst_n = 1'b0;
    #1;
    checkOutput("n5_midrst_out_valid", 32'(ov5), 32'h0);
    checkOutput("n5_midrst_in_ready", 32'(irdy5), 32'h0);
    checkOutput("n5_midrst_out_sel", 32'(os5), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("n5_after_rst_in_ready", 32'(irdy5), 32'h01);
    @(negedge clk);

    // Randomized traffic on the N=8 round-robin instance against a model
    // that tracks pending requests and the expected output register.
    doReset();
    for (int i = 0; i < N; i++) begin
      pend[i]   = 1'b0;
      pdata[i]  = 8'h00;
      prev_d[i] = 8'h00;
    end
    prev_v   = '0;
    prev_acc = '0;
    m_valid  = 1'b0;
    m_data   = 8'h00;
    m_sel    = 8'h00;
    m_ptr    = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      dens = ((cyc / 100) % 2 == 1) ? 7 : 1;
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && $urandom_range(0, dens) == 0) begin
          pend[i]  = 1'b1;
          pdata[i] = 8'($urandom);
        end
        iv[i]        = pend[i];
        id[i*W +: W] = pdata[i];
      end
      ordy = ($urandom_range(0, 3) != 0);

      // Source rule: a request not accepted last cycle is still offered
      // with the same data.
      for (int i = 0; i < N; i++) begin
        if (prev_v[i] && !prev_acc[i]) begin
          checks++;
          assert (iv[i] && id[i*W +: W] == prev_d[i])
          else begin
            errors++;
            $display("[TB] FAIL src_rule ch%0d: valid=%0b data=0x%0h, required valid=1 data=0x%0h",
                     i, iv[i], id[i*W +: W], prev_d[i]);
          end
        end
      end

      #1;
      mload  = !m_valid || ordy;
      g      = modelPick(iv, m_ptr, 1'b0, N);
      e_irdy = (mload && g >= 0) ? 8'(1 << g) : 8'h00;
      checkOutput("rnd_in_ready", 32'(irdy), 32'(e_irdy));
      checkOutput("rnd_out_valid", 32'(ov), 32'(m_valid));
      checkOutput("rnd_out_sel", 32'(os), 32'(m_sel));
      checkOutput("rnd_out_data", 32'(od), 32'(m_data));

      prev_v   = iv;
      prev_acc = irdy;
      for (int i = 0; i < N; i++) prev_d[i] = id[i*W +: W];

      if (mload) begin
        if (g >= 0) begin
          m_valid = 1'b1;
          m_data  = pdata[g];
          m_sel   = 8'(1 << g);
          m_ptr   = (g + 1) % N;
          pend[g] = 1'b0;
        end else begin
          m_valid = 1'b0;
        end
      end
      @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
